switch_output_queue: RTL and testbench

- Multi-port output buffer bank for the switch.
- Accepts bytes from the switch fabric, tagged with a destination port.
- Queues them in one independent FIFO per output port.
- Presents each queue on a port_out / port_ready / port_read handshake, generalised to NUM_PORTS channels, DATA_W width and DEPTH entries.
- Adds per-port flush, fill-level reporting and a saturating drop counter.

---
 rtl/switch_output_queue.sv | 107 ++++++++++
 tb/tb_switch_output_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/switch_output_queue.sv
// switch_output_queue: per-port show-ahead output FIFOs fed by one fabric
// write port. Each queue has its own flush, fill level and ready/read
// handshake. A shared saturating counter records bytes dropped on full queues.
module switch_output_queue #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          wr_valid,
  input  logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] wr_port,
  input  logic [DATA_W-1:0]                             wr_data,
  output logic                                          wr_ready,
  input  logic [NUM_PORTS-1:0]                          flush,
  output logic [NUM_PORTS*DATA_W-1:0]                   port_out,
  output logic [NUM_PORTS-1:0]                          port_ready,
  input  logic [NUM_PORTS-1:0]                          port_read,
  output logic [NUM_PORTS*($clog2(DEPTH)+1)-1:0]        level,
  output logic [CNT_W-1:0]                              drop_cnt
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  logic [DATA_W-1:0]    mem    [NUM_PORTS][DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_PORTS];
  logic [PW-1:0]        rd_ptr [NUM_PORTS];

  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 drop_evt;

  // Queue status, write steering and pop qualification from registered pointers.
  // An out-of-range wr_port matches no queue, so it neither writes nor drops.
  always_comb begin
    hit   = '0;
    full  = '0;
    empty = '0;
    push  = '0;
    pop   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p]   = (wr_port == PORT_W'(p));
      empty[p] = (wr_ptr[p] == rd_ptr[p]);
      full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                 (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
      push[p]  = wr_valid && hit[p] && !full[p] && !flush[p];
      pop[p]   = port_read[p] && !empty[p] && !flush[p];
    end
    wr_ready = |(hit & ~full & ~flush);
    drop_evt = wr_valid && |(hit & full & ~flush);
  end

  // Pointer update per queue; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (flush[p]) begin
          wr_ptr[p] <= '0;
          rd_ptr[p] <= '0;
        end else begin
          if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
          if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: lanes are masked to zero while a queue is empty.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= wr_data;
    end
  end

  // Saturating count of bytes rejected by a full, non-flushing queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Show-ahead heads, ready flags and occupancy, all from registered state.
  always_comb begin
    port_out   = '0;
    port_ready = '0;
    level      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_ready[p] = !empty[p];
      level[p*PW +: PW] = wr_ptr[p] - rd_ptr[p];
      if (!empty[p]) port_out[p*DATA_W +: DATA_W] = mem[p][rd_ptr[p][AW-1:0]];
    end
  end

endmodule

// File: tb/tb_switch_output_queue.sv
// Directed bench for switch_output_queue (4 ports, 8-bit, depth 8, 2-bit
// drop counter so saturation is reachable).
module tb_switch_output_queue;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 2;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [1:0]    wr_port;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [NP-1:0] flush;
  logic [NP*DW-1:0] port_out;
  logic [NP-1:0] port_ready;
  logic [NP-1:0] port_read;
  logic [NP*LW-1:0] level;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  switch_output_queue #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_port(wr_port),
    .wr_data(wr_data), .wr_ready(wr_ready), .flush(flush), .port_out(port_out),
    .port_ready(port_ready), .port_read(port_read), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] lane(input int p);
    return port_out[p*DW +: DW];
  endfunction

  function automatic logic [LW-1:0] lvl(input int p);
    return level[p*LW +: LW];
  endfunction

  task automatic wr(input logic [1:0] p, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_port  = p;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_port = '0; wr_data = '0;
    flush = '0; port_read = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", port_ready, 0);
    check("rst_out", port_out, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick();

    // single byte on port 2
    wr(2'd2, 8'hA5);
    check("t1_ready", port_ready, 4'b0100);
    check("t1_lane2", lane(2), 8'hA5);
    check("t1_level2", lvl(2), 1);
    port_read = 4'b0100;
    tick();
    port_read = '0;
    check("t1_ready_after_pop", port_ready, 0);
    check("t1_lane2_after_pop", lane(2), 0);

    // fill port 0, overflow once, drain at full rate
    for (int i = 0; i < 8; i++) wr(2'd0, 8'(8'h10 + i));
    check("t2_level0_full", lvl(0), 8);
    wr_port = 2'd0;
    #1;
    check("t2_wr_ready_full", wr_ready, 0);
    wr_port = 2'd1;
    #1;
    check("t2_wr_ready_other", wr_ready, 1);
    wr(2'd0, 8'h18);
    check("t2_drop", drop_cnt, 1);
    check("t2_level0_after_drop", lvl(0), 8);
    port_read = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_drain%0d", i), lane(0), 8'(8'h10 + i));
      tick();
    end
    port_read = '0;
    check("t2_ready0_drained", port_ready[0], 0);
    check("t2_level0_drained", lvl(0), 0);

    // simultaneous write+pop on port 1, then write to port 3
    wr(2'd1, 8'h21); wr(2'd1, 8'h22); wr(2'd1, 8'h23);
    check("t3_level1", lvl(1), 3);
    port_read = 4'b0010;
    wr(2'd1, 8'h24);
    port_read = '0;
    check("t3_level1_wr_pop", lvl(1), 3);
    check("t3_head1", lane(1), 8'h22);
    wr(2'd3, 8'h33);
    check("t3_level3", lvl(3), 1);
    check("t3_level1_unaff", lvl(1), 3);
    check("t3_lane3", lane(3), 8'h33);
    port_read = 4'b1010;
    tick();
    port_read = 4'b0010;
    check("t3_order_a", lane(1), 8'h23);
    check("t3_level3_pop", lvl(3), 0);
    tick();
    check("t3_order_b", lane(1), 8'h24);
    tick();
    port_read = '0;
    check("t3_level1_empty", lvl(1), 0);

    // read on empty queue, then write+pop on empty queue
    port_read = 4'b0010;
    repeat (5) tick();
    check("t4_level1_idle", lvl(1), 0);
    check("t4_ready_idle", port_ready, 0);
    wr(2'd1, 8'h3C);
    check("t4_level1_write", lvl(1), 1);
    check("t4_lane1", lane(1), 8'h3C);
    tick();
    port_read = '0;
    check("t4_level1_popped", lvl(1), 0);
    check("t4_lane1_popped", lane(1), 0);

    // flush with a same-cycle write
    for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'h50 + i));
    check("t5_level0", lvl(0), 5);
    flush = 4'b0001;
    wr_valid = 1'b1; wr_port = 2'd0; wr_data = 8'h99;
    #1;
    check("t5_wr_ready_flush", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    flush = '0;
    check("t5_level0_flushed", lvl(0), 0);
    check("t5_ready0_flushed", port_ready[0], 0);
    check("t5_drop_unchanged", drop_cnt, 1);
    wr(2'd0, 8'h77);
    check("t5_lane0_after", lane(0), 8'h77);
    check("t5_level0_after", lvl(0), 1);

    // saturate drop counter on port 2
    for (int i = 0; i < 8; i++) wr(2'd2, 8'(8'hC0 + i));
    check("t6_level2_full", lvl(2), 8);
    for (int i = 0; i < 5; i++) begin
      wr(2'd2, 8'hEE);
      check($sformatf("t6_drop%0d", i), drop_cnt, (i == 0) ? 2 : 3);
    end
    check("t6_lane2_head", lane(2), 8'hC0);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("t7_ready", port_ready, 0);
    check("t7_out", port_out, 0);
    check("t7_level", level, 0);
    check("t7_drop", drop_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t7_ready_post", port_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
